// File: rtl/sram_arb_pkg.sv
// Shared types and the round-robin pick helper for the SRAM port arbiters.
// Latency: purely combinational helpers, no state.
// Backpressure: not applicable; the helper only ranks pending requests.
package sram_arb_pkg;

  localparam int MAX_REQ = 8;

  typedef logic [2:0] req_idx_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  typedef struct packed {
    logic     found;
    req_idx_t idx;
  } pick_t;

  // Scan ptr, ptr+1, ... wrapping explicitly after 'last' (the highest real
  // requester index), and return the first requester with valid set.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input req_idx_t           ptr,
                                    input req_idx_t           last);
    pick_t    res;
    req_idx_t cand;
    res  = '0;
    cand = ptr;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (!res.found && valid[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
      cand = (cand == last) ? 3'd0 : cand + 3'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating find-first: picks the first set valid bit at or after ptr, wrapping at N-1.
// Latency: combinational.
// Backpressure: none; found=0 when no bit is set.
module rr_priority_pick
  import sram_arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int       IDX_W = $clog2(N);
  localparam req_idx_t LAST  = req_idx_t'(N - 1);

  logic [MAX_REQ-1:0] valid_ext;
  pick_t              pick;

  // Widen to the package's fixed width, pick, and never report an index
  // outside the populated requester range.
  always_comb begin
    valid_ext        = '0;
    valid_ext[N-1:0] = valid;
    pick             = rr_pick(valid_ext, req_idx_t'(ptr), LAST);
    found            = pick.found && (pick.idx <= LAST);
    idx              = pick.idx[IDX_W-1:0];
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM macro between NUM_REQ requesters: round-robin with an optional burst lock.
// Latency: grant and SRAM drive are combinational in the accept cycle; read data returns exactly one cycle later.
// Backpressure: req_ready withheld from losers and from non-owners while locked; responses cannot be stalled.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      sram_cs,
  output logic                      sram_we,
  output logic [ADDR_W-1:0]         sram_addr,
  output logic [DATA_W-1:0]         sram_din,
  input  logic [DATA_W-1:0]         sram_dout
);

  localparam int               IDX_W     = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [3:0]       BURST_MAX = 4'(MAX_BURST);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] owner, owner_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             tag_vld;
  logic [IDX_W-1:0] tag_idx;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             gnt_vld;
  logic [IDX_W-1:0] gnt_idx;

  // Wrap is an explicit compare so non-power-of-two requester counts rotate correctly.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
  endfunction

  rr_priority_pick #(.N(NUM_REQ)) u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Grant: round-robin winner when idle, only the owner while locked, nothing in reset.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = pick_idx;
    if (!rst) begin
      if (state == ARB_LOCKED) begin
        gnt_vld = req_valid[owner];
        gnt_idx = owner;
      end else begin
        gnt_vld = pick_found;
      end
    end
  end

  // Handshake, SRAM mux and response decode; idle bus is driven to zero.
  always_comb begin
    req_ready = '0;
    sram_cs   = gnt_vld;
    sram_we   = 1'b0;
    sram_addr = '0;
    sram_din  = '0;
    rsp_valid = '0;
    rsp_rdata = sram_dout;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_vld && (gnt_idx == IDX_W'(i))) begin
        req_ready[i] = 1'b1;
        sram_we      = req_we[i];
        sram_addr    = req_addr[i*ADDR_W +: ADDR_W];
        sram_din     = req_wdata[i*DATA_W +: DATA_W];
      end
    end
    // A read in flight when reset arrives is dropped, not reported.
    if (tag_vld && !rst) begin
      rsp_valid[tag_idx] = 1'b1;
    end
  end

  // Lock FSM and pointer next-state; leaving a lock always hands priority to owner+1.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    if (state == ARB_IDLE) begin
      if (gnt_vld) begin
        if (req_lock[gnt_idx] && (BURST_MAX > 4'd1)) begin
          state_nxt = ARB_LOCKED;
          owner_nxt = gnt_idx;
          cnt_nxt   = 4'd1;
        end else begin
          ptr_nxt = wrap_inc(gnt_idx);
        end
      end
    end else begin
      if (!req_valid[owner] || !req_lock[owner] || ((cnt + 4'd1) >= BURST_MAX)) begin
        state_nxt = ARB_IDLE;
        cnt_nxt   = 4'd0;
        ptr_nxt   = wrap_inc(owner);
      end else begin
        cnt_nxt = cnt + 4'd1;
      end
    end
  end

  // State registers plus the one-deep read tag; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB_IDLE;
      ptr     <= '0;
      owner   <= '0;
      cnt     <= '0;
      tag_vld <= 1'b0;
      tag_idx <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      owner   <= owner_nxt;
      cnt     <= cnt_nxt;
      tag_vld <= gnt_vld && !sram_we;
      tag_idx <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios followed by a random phase against a reference model.
// Latency: model predicts grant in the same cycle and read data one cycle later.
// Backpressure: requesters hold a request until granted, with occasional voluntary drops.
module tb_sram_port_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    valid, we, lock;
  logic [AW-1:0]   addr  [N];
  logic [DW-1:0]   wdata [N];
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    ready, rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            sram_cs, sram_we;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_din, sram_dout;

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign req_addr[gi*AW +: AW]  = addr[gi];
    assign req_wdata[gi*DW +: DW] = wdata[gi];
  end

  sram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (valid),
    .req_ready (ready),
    .req_we    (we),
    .req_lock  (lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .sram_cs   (sram_cs),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  // SRAM macro stand-in: synchronous write, registered read.
  logic [DW-1:0] sram_mem [16];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) sram_mem[sram_addr] <= sram_din;
      else         sram_dout <= sram_mem[sram_addr];
    end
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, kept as plain integers.
  int            m_ptr, m_owner, m_cnt;
  bit            m_locked;
  bit            m_pend;
  int            m_pend_idx;
  logic [DW-1:0] m_pend_data;
  logic [DW-1:0] m_mem [16];

  int            gnt_log[$];
  bit            last_gv;
  int            last_g;
  logic [N-1:0]  last_rsp_valid;
  logic [DW-1:0] last_rsp_data;
  logic          last_cs;

  int exp3[8] = '{0, 1, 2, 0, 1, 2, 0, 1};
  int exp4[6] = '{2, 2, 2, 2, 0, 1};
  int exp5[4] = '{2, 2, -1, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_ptr    = 0;
    m_owner  = 0;
    m_cnt    = 0;
    m_locked = 1'b0;
    m_pend   = 1'b0;
  endfunction

  // Who should win this cycle, from the arbitration rules.
  function automatic void model_grant(output bit gv, output int g);
    gv = 1'b0;
    g  = 0;
    if (rst) return;
    if (m_locked) begin
      if (valid[m_owner]) begin
        gv = 1'b1;
        g  = m_owner;
      end
      return;
    end
    for (int k = 0; k < N; k++) begin
      if (!gv && valid[(m_ptr + k) % N]) begin
        gv = 1'b1;
        g  = (m_ptr + k) % N;
      end
    end
  endfunction

  // Advance the model across a clock edge.
  function automatic void model_update(input bit gv, input int g);
    if (rst) begin
      model_reset();
      return;
    end
    m_pend = 1'b0;
    if (gv) begin
      if (we[g]) m_mem[addr[g]] = wdata[g];
      else begin
        m_pend      = 1'b1;
        m_pend_idx  = g;
        m_pend_data = m_mem[addr[g]];
      end
    end
    if (m_locked) begin
      if (!gv) begin
        m_locked = 1'b0;
        m_ptr    = (m_owner + 1) % N;
      end else begin
        m_cnt++;
        if (!lock[g] || m_cnt >= MB) begin
          m_locked = 1'b0;
          m_ptr    = (m_owner + 1) % N;
        end
      end
    end else if (gv) begin
      if (lock[g]) begin
        m_owner  = g;
        m_cnt    = 1;
        m_locked = (m_cnt < MB);
        if (!m_locked) m_ptr = (g + 1) % N;
      end else begin
        m_ptr = (g + 1) % N;
      end
    end
  endfunction

  // One clock: predict, sample at negedge, advance model at posedge, then release inputs.
  task automatic step();
    bit           gv;
    int           g;
    int           obs;
    logic [N-1:0] exp_ready, exp_rsp;
    model_grant(gv, g);
    exp_ready = '0;
    if (gv) exp_ready[g] = 1'b1;
    exp_rsp = '0;
    if (m_pend && !rst) exp_rsp[m_pend_idx] = 1'b1;
    @(negedge clk);
    chk("req_ready", 64'(ready), 64'(exp_ready));
    chk("sram_cs",   64'(sram_cs), 64'(gv));
    chk("sram_we",   64'(sram_we), 64'(gv && we[g]));
    chk("sram_addr", 64'(sram_addr), gv ? 64'(addr[g]) : 64'd0);
    chk("sram_din",  64'(sram_din), gv ? 64'(wdata[g]) : 64'd0);
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
    if (exp_rsp != '0) chk("rsp_rdata", 64'(rsp_rdata), 64'(m_pend_data));
    obs = -1;
    for (int i = 0; i < N; i++) if (ready[i]) obs = i;
    gnt_log.push_back(obs);
    last_rsp_valid = rsp_valid;
    last_rsp_data  = rsp_rdata;
    last_cs        = sram_cs;
    @(posedge clk);
    model_update(gv, g);
    last_gv = gv;
    last_g  = g;
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    valid = '0;
    we    = '0;
    lock  = '0;
    for (int i = 0; i < N; i++) begin
      addr[i]  = '0;
      wdata[i] = '0;
    end
    model_reset();
    @(posedge clk);
    #1;

    // Reset state, then an idle stretch.
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) step();

    // Fill every SRAM word through requester 0 so later reads have known data.
    for (int a = 0; a < 16; a++) begin
      valid    = 3'b001;
      we       = 3'b001;
      addr[0]  = 4'(a);
      wdata[0] = $urandom;
      step();
    end
    valid = '0;
    step();

    // Write then read back through a different requester.
    valid = 3'b001; we = 3'b001; addr[0] = 4'd3; wdata[0] = 32'hDEADBEEF;
    step();
    valid = '0;
    step();
    valid = 3'b010; we = 3'b000; addr[1] = 4'd3;
    step();
    chk("t2_gnt", 64'(gnt_log[$]), 64'(1));
    valid = '0;
    step();
    chk("t2_rsp_valid", 64'(last_rsp_valid), 64'(3'b010));
    chk("t2_rdata", 64'(last_rsp_data), 64'(32'hDEADBEEF));

    // Plain rotation from a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    valid = 3'b111; we = 3'b010; lock = 3'b000;
    addr[0] = 4'd5; addr[1] = 4'd6; addr[2] = 4'd7;
    gnt_log.delete();
    for (int c = 0; c < 8; c++) step();
    for (int k = 0; k < 8; k++) chk($sformatf("t3_gnt%0d", k), 64'(gnt_log[k]), 64'(exp3[k]));

    // Burst lock by requester 2 caps at four grants.
    lock = 3'b100;
    gnt_log.delete();
    for (int c = 0; c < 6; c++) step();
    for (int k = 0; k < 6; k++) chk($sformatf("t4_gnt%0d", k), 64'(gnt_log[k]), 64'(exp4[k]));

    // Owner drops valid mid-burst.
    gnt_log.delete();
    step();
    step();
    valid = 3'b011;
    step();
    chk("t5_cs", 64'(last_cs), 64'(0));
    valid = 3'b111;
    lock  = 3'b000;
    step();
    for (int k = 0; k < 4; k++) chk($sformatf("t5_gnt%0d", k), 64'(gnt_log[k]), 64'(exp5[k]));

    // Reset right behind an accepted read.
    valid = 3'b001; we = 3'b000; addr[0] = 4'd3;
    step();
    rst   = 1'b1;
    valid = '0;
    step();
    chk("t6_rsp", 64'(last_rsp_valid), 64'(0));
    rst   = 1'b0;
    valid = 3'b111;
    step();
    chk("t6_gnt", 64'(gnt_log[$]), 64'(0));
    valid = '0;
    step();

    // Random traffic: requests held until granted, occasional drops and resets.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!valid[i] || (last_gv && last_g == i) || $urandom_range(15) == 0) begin
          valid[i] = ($urandom_range(3) != 0);
          we[i]    = $urandom_range(1) == 1;
          lock[i]  = $urandom_range(1) == 1;
          addr[i]  = 4'($urandom_range(15));
          wdata[i] = $urandom;
        end
      end
      rst = ($urandom_range(63) == 0);
      step();
    end
    rst   = 1'b0;
    valid = '0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
